// File: rtl/bus_pkg.sv
// Shared constants, decoder state encoding and helpers for the serial bus
// address decoder and its routing crossbar.
package bus_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int NUM_SLAVES  = 3;
  localparam int DEV_W       = 2;

  localparam int M_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int S_IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W   = $clog2(DEV_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_ACK     = 2'd2,
    ST_CONNECT = 2'd3
  } dec_state_e;

  // Lowest set bit wins, so an illegal multi-bit grant still yields one master.
  function automatic logic [M_IDX_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [M_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (oh[i]) begin
        idx = M_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic dev_in_range(input logic [DEV_W-1:0] dev);
    return ({{(32 - DEV_W){1'b0}}, dev} < 32'(NUM_SLAVES));
  endfunction

endpackage

// File: rtl/bus_route_mux.sv
// Combinational crossbar joining one master port to one slave port while
// a connection is open; every unselected line is held at 0.
module bus_route_mux #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter int MW = (NM > 1) ? $clog2(NM) : 1,
  parameter int SW = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic          i_en,
  input  logic [MW-1:0] i_g,
  input  logic [SW-1:0] i_sel,
  input  logic [NM-1:0] i_m_wr_bus,
  input  logic [NM-1:0] i_m_master_valid,
  input  logic [NM-1:0] i_m_master_ready,
  input  logic [NM-1:0] i_m_mode,
  input  logic [NS-1:0] i_s_rd_bus,
  input  logic [NS-1:0] i_s_slave_valid,
  input  logic [NS-1:0] i_s_slave_ready,
  output logic [NM-1:0] o_m_rd_bus,
  output logic [NM-1:0] o_m_slave_valid,
  output logic [NM-1:0] o_m_slave_ready,
  output logic [NS-1:0] o_s_wr_bus,
  output logic [NS-1:0] o_s_master_valid,
  output logic [NS-1:0] o_s_master_ready,
  output logic [NS-1:0] o_s_mode
);

  logic w_m_wr;
  logic w_m_mv;
  logic w_m_mr;
  logic w_m_md;
  logic w_s_rd;
  logic w_s_sv;
  logic w_s_sr;

  // Master-to-slave direction: fan the active master's lines to the selected slave.
  always_comb begin
    w_m_wr = i_m_wr_bus[i_g];
    w_m_mv = i_m_master_valid[i_g];
    w_m_mr = i_m_master_ready[i_g];
    w_m_md = i_m_mode[i_g];
    for (int s = 0; s < NS; s++) begin
      o_s_wr_bus[s]       = i_en && (i_sel == SW'(s)) && w_m_wr;
      o_s_master_valid[s] = i_en && (i_sel == SW'(s)) && w_m_mv;
      o_s_master_ready[s] = i_en && (i_sel == SW'(s)) && w_m_mr;
      o_s_mode[s]         = i_en && (i_sel == SW'(s)) && w_m_md;
    end
  end

  // Slave-to-master direction: gather the selected slave's lines.
  always_comb begin
    w_s_rd = 1'b0;
    w_s_sv = 1'b0;
    w_s_sr = 1'b0;
    for (int s = 0; s < NS; s++) begin
      w_s_rd = w_s_rd | ((i_sel == SW'(s)) && i_s_rd_bus[s]);
      w_s_sv = w_s_sv | ((i_sel == SW'(s)) && i_s_slave_valid[s]);
      w_s_sr = w_s_sr | ((i_sel == SW'(s)) && i_s_slave_ready[s]);
    end
    for (int m = 0; m < NM; m++) begin
      o_m_rd_bus[m]      = i_en && (i_g == MW'(m)) && w_s_rd;
      o_m_slave_valid[m] = i_en && (i_g == MW'(m)) && w_s_sv;
      o_m_slave_ready[m] = i_en && (i_g == MW'(m)) && w_s_sr;
    end
  end

endmodule

// File: rtl/bus_decoder.sv
// Device-select decoder and routing controller: snoops the granted master's
// select bits, acknowledges, routes the bus and parks/resumes one split.
module bus_decoder
  import bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_bgrant,
  input  logic [NUM_MASTERS-1:0] m_wr_bus,
  input  logic [NUM_MASTERS-1:0] m_master_valid,
  input  logic [NUM_MASTERS-1:0] m_master_ready,
  input  logic [NUM_MASTERS-1:0] m_mode,
  output logic [NUM_MASTERS-1:0] m_rd_bus,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  output logic [NUM_MASTERS-1:0] m_ack,
  output logic [NUM_MASTERS-1:0] m_split,
  output logic [NUM_SLAVES-1:0]  s_wr_bus,
  output logic [NUM_SLAVES-1:0]  s_master_valid,
  output logic [NUM_SLAVES-1:0]  s_master_ready,
  output logic [NUM_SLAVES-1:0]  s_mode,
  input  logic [NUM_SLAVES-1:0]  s_rd_bus,
  input  logic [NUM_SLAVES-1:0]  s_slave_valid,
  input  logic [NUM_SLAVES-1:0]  s_slave_ready,
  input  logic [NUM_SLAVES-1:0]  s_split
);

  dec_state_e           r_state;
  logic [M_IDX_W-1:0]   r_g;
  logic [S_IDX_W-1:0]   r_sel;
  logic [DEV_W-1:0]     r_dev;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_resume;
  logic                 r_split_pend;
  logic [M_IDX_W-1:0]   r_split_m;
  logic [S_IDX_W-1:0]   r_split_s;
  logic                 r_split_prev;
  logic                 r_resume_rdy;

  logic                   w_granted;
  logic                   w_dev_ok;
  logic                   w_ack_now;
  logic                   w_route_en;
  logic                   w_decoding;
  logic [NUM_MASTERS-1:0] w_mux_slave_ready;

  // Per-cycle decisions derived from the registered state.
  always_comb begin
    w_granted  = m_bgrant[r_g];
    w_dev_ok   = dev_in_range(r_dev) &&
                 !(r_split_pend && (S_IDX_W'(r_dev) == r_split_s));
    w_ack_now  = (r_state == ST_ACK) && w_granted && (r_resume || w_dev_ok);
    w_route_en = (r_state == ST_CONNECT);
    w_decoding = (r_state == ST_DECODE);
  end

  // Decoder FSM plus split bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_g          <= '0;
      r_sel        <= '0;
      r_dev        <= '0;
      r_cnt        <= '0;
      r_resume     <= 1'b0;
      r_split_pend <= 1'b0;
      r_split_m    <= '0;
      r_split_s    <= '0;
      r_split_prev <= 1'b0;
      r_resume_rdy <= 1'b0;
    end else begin
      // Release is the falling edge of the parked slave's split line.
      r_split_prev <= s_split[r_split_s];
      if (r_split_pend && r_split_prev && !s_split[r_split_s]) begin
        r_resume_rdy <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_resume_rdy && m_bgrant[r_split_m]) begin
            r_state      <= ST_ACK;
            r_g          <= r_split_m;
            r_sel        <= r_split_s;
            r_resume     <= 1'b1;
            r_split_pend <= 1'b0;
            r_resume_rdy <= 1'b0;
          end else if (m_bgrant != '0) begin
            r_state  <= ST_DECODE;
            r_g      <= onehot_to_idx(m_bgrant);
            r_cnt    <= '0;
            r_dev    <= '0;
            r_resume <= 1'b0;
          end
        end
        ST_DECODE: begin
          if (!w_granted) begin
            r_state <= ST_IDLE;
          end else if (m_master_valid[r_g]) begin
            r_dev <= DEV_W'({r_dev, m_wr_bus[r_g]});
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DEV_W - 1)) begin
              r_state <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          r_resume <= 1'b0;
          if (w_ack_now) begin
            r_state <= ST_CONNECT;
            if (!r_resume) begin
              r_sel <= S_IDX_W'(r_dev);
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CONNECT: begin
          // A split while another is parked is ignored and runs to completion.
          if (s_split[r_sel] && !r_split_pend) begin
            r_split_pend <= 1'b1;
            r_split_m    <= r_g;
            r_split_s    <= r_sel;
            r_split_prev <= 1'b1;
            r_resume_rdy <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (!w_granted) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  bus_route_mux #(
    .NM(NUM_MASTERS),
    .NS(NUM_SLAVES),
    .MW(M_IDX_W),
    .SW(S_IDX_W)
  ) u_route (
    .i_en             (w_route_en),
    .i_g              (r_g),
    .i_sel            (r_sel),
    .i_m_wr_bus       (m_wr_bus),
    .i_m_master_valid (m_master_valid),
    .i_m_master_ready (m_master_ready),
    .i_m_mode         (m_mode),
    .i_s_rd_bus       (s_rd_bus),
    .i_s_slave_valid  (s_slave_valid),
    .i_s_slave_ready  (s_slave_ready),
    .o_m_rd_bus       (m_rd_bus),
    .o_m_slave_valid  (m_slave_valid),
    .o_m_slave_ready  (w_mux_slave_ready),
    .o_s_wr_bus       (s_wr_bus),
    .o_s_master_valid (s_master_valid),
    .o_s_master_ready (s_master_ready),
    .o_s_mode         (s_mode)
  );

  // Per-master ack, split flag, and the decoder-owned ready during select.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      m_ack[m]         = w_ack_now && (r_g == M_IDX_W'(m));
      m_split[m]       = r_split_pend && (r_split_m == M_IDX_W'(m));
      m_slave_ready[m] = w_mux_slave_ready[m] | (w_decoding && (r_g == M_IDX_W'(m)));
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Randomized scoreboard bench for bus_decoder: a connection-level model
// predicts acks, routing and split flags; a monitor compares every cycle.
module tb_bus_decoder;
  import bus_pkg::*;

  localparam int NM = NUM_MASTERS;
  localparam int NS = NUM_SLAVES;
  localparam int DW = DEV_W;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NM-1:0] m_bgrant, m_wr_bus, m_master_valid, m_master_ready, m_mode;
  logic [NM-1:0] m_rd_bus, m_slave_valid, m_slave_ready, m_ack, m_split;
  logic [NS-1:0] s_wr_bus, s_master_valid, s_master_ready, s_mode;
  logic [NS-1:0] s_rd_bus, s_slave_valid, s_slave_ready, s_split;

  bus_decoder dut (
    .clk(clk), .rstn(rstn),
    .m_bgrant(m_bgrant), .m_wr_bus(m_wr_bus), .m_master_valid(m_master_valid),
    .m_master_ready(m_master_ready), .m_mode(m_mode),
    .m_rd_bus(m_rd_bus), .m_slave_valid(m_slave_valid), .m_slave_ready(m_slave_ready),
    .m_ack(m_ack), .m_split(m_split),
    .s_wr_bus(s_wr_bus), .s_master_valid(s_master_valid),
    .s_master_ready(s_master_ready), .s_mode(s_mode),
    .s_rd_bus(s_rd_bus), .s_slave_valid(s_slave_valid),
    .s_slave_ready(s_slave_ready), .s_split(s_split)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: what connection exists, who is decoding, what is parked.
  bit conn_on = 1'b0, dec_on = 1'b0, split_pend_m = 1'b0, mon_en = 1'b0;
  int conn_m = 0, conn_s = 0, dec_m = 0, split_m_m = 0, split_s_m = 0;

  typedef struct { int m; int cyc; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic monitor_cycle();
    logic [NM-1:0] e_rd, e_sv, e_sr, e_sp;
    logic [NS-1:0] e_wr, e_mv, e_mr, e_md;
    exp_t e;
    e_rd = '0; e_sv = '0; e_sr = '0; e_sp = '0;
    e_wr = '0; e_mv = '0; e_mr = '0; e_md = '0;
    if (conn_on) begin
      e_wr[conn_s] = m_wr_bus[conn_m];
      e_mv[conn_s] = m_master_valid[conn_m];
      e_mr[conn_s] = m_master_ready[conn_m];
      e_md[conn_s] = m_mode[conn_m];
      e_rd[conn_m] = s_rd_bus[conn_s];
      e_sv[conn_m] = s_slave_valid[conn_s];
      e_sr[conn_m] = s_slave_ready[conn_s];
    end else if (dec_on) begin
      e_sr[dec_m] = 1'b1;
    end
    if (split_pend_m) e_sp[split_m_m] = 1'b1;
    check("route",
          32'({m_rd_bus, m_slave_valid, m_slave_ready, s_wr_bus, s_master_valid, s_master_ready, s_mode}),
          32'({e_rd, e_sv, e_sr, e_wr, e_mv, e_mr, e_md}));
    check("split_flag", 32'(m_split), 32'(e_sp));
    if (m_ack != '0) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(m_ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_master", 32'(m_ack), 32'(1 << e.m));
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
      e = exp_q.pop_front();
      check("ack_missing", 32'(m_ack), 32'(1 << e.m));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) monitor_cycle();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lines();
    m_wr_bus = '0; m_master_valid = '0; m_master_ready = '0; m_mode = '0;
    s_rd_bus = '0; s_slave_valid = '0; s_slave_ready = '0;
  endtask

  task automatic randomize_lines();
    m_wr_bus = 2'($urandom); m_master_valid = 2'($urandom);
    m_master_ready = 2'($urandom); m_mode = 2'($urandom);
    s_rd_bus = 3'($urandom); s_slave_valid = 3'($urandom); s_slave_ready = 3'($urandom);
  endtask

  function automatic bit model_ok(input int dev);
    return (dev < NS) && !(split_pend_m && dev == split_s_m);
  endfunction

  task automatic check_all_zero(input string name);
    check(name, 32'({m_rd_bus, m_slave_valid, m_slave_ready, m_ack, m_split,
                     s_wr_bus, s_master_valid, s_master_ready, s_mode}), 32'd0);
  endtask

  // Grant master m, shift dev MSB-first with `gap` idle cycles after the first bit.
  task automatic start_txn(input int m, input int dev, input int gap, output bit acked);
    int g0;
    m_bgrant = '0;
    m_bgrant[m] = 1'b1;
    g0 = cyc;
    acked = model_ok(dev);
    if (acked) exp_q.push_back('{m, g0 + 1 + DW + gap});
    tick();
    dec_on = 1'b1; dec_m = m;
    for (int b = DW - 1; b >= 0; b--) begin
      m_master_valid[m] = 1'b1;
      m_wr_bus[m] = dev[b];
      tick();
      m_master_valid[m] = 1'b0;
      m_wr_bus[m] = 1'b0;
      if (b == DW - 1) repeat (gap) tick();
    end
    dec_on = 1'b0;
    tick();
    if (acked) begin
      conn_on = 1'b1; conn_m = m; conn_s = dev;
    end else begin
      m_bgrant = '0;
      tick();
    end
  endtask

  task automatic run_conn(input int n);
    repeat (n) begin
      randomize_lines();
      tick();
    end
  endtask

  task automatic end_conn();
    m_bgrant = '0;
    clear_lines();
    tick();
    conn_on = 1'b0;
    tick();
  endtask

  task automatic do_split();
    s_split[conn_s] = 1'b1;
    m_bgrant = '0;
    clear_lines();
    tick();
    conn_on = 1'b0;
    split_pend_m = 1'b1; split_m_m = conn_m; split_s_m = conn_s;
    tick();
  endtask

  task automatic ignored_split();
    s_split[conn_s] = 1'b1;
    randomize_lines();
    tick();
    s_split[conn_s] = 1'b0;
    randomize_lines();
    tick();
  endtask

  task automatic release_and_resume(input int wait_cyc);
    s_split[split_s_m] = 1'b0;
    tick();
    repeat (wait_cyc) tick();
    m_bgrant = '0;
    m_bgrant[split_m_m] = 1'b1;
    exp_q.push_back('{split_m_m, cyc + 1});
    tick();
    split_pend_m = 1'b0;
    tick();
    conn_on = 1'b1; conn_m = split_m_m; conn_s = split_s_m;
  endtask

  initial begin
    bit ok;
    int r;
    rstn = 1'b0;
    m_bgrant = '0; s_split = '0;
    clear_lines();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rstn = 1'b1;
    mon_en = 1'b1;
    tick();

    // Device 1 from master 0, then device 3 from master 1 (nack).
    start_txn(0, 1, 0, ok); run_conn(4); end_conn();
    start_txn(1, 3, 0, ok);
    tick();

    // Split on slave index 1, parked-slave nack, other slave acks, release and resume.
    start_txn(0, 1, 0, ok); run_conn(2); do_split();
    start_txn(1, 1, 0, ok);
    start_txn(1, 2, 0, ok); run_conn(2); ignored_split(); end_conn();
    release_and_resume(1); run_conn(3); end_conn();

    // Valid gap of two cycles inside the device select.
    start_txn(1, 2, 2, ok); run_conn(2); end_conn();

    for (int i = 0; i < 80; i++) begin
      start_txn(int'($urandom_range(0, NM - 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), ok);
      if (ok) begin
        run_conn(int'($urandom_range(1, 4)));
        r = int'($urandom_range(0, 3));
        if (r == 0 && !split_pend_m) begin
          do_split();
        end else if (r == 1 && split_pend_m) begin
          ignored_split();
          end_conn();
        end else begin
          end_conn();
        end
      end
      if (split_pend_m && $urandom_range(0, 2) == 0) begin
        release_and_resume(int'($urandom_range(0, 2)));
        run_conn(2);
        end_conn();
      end
    end
    if (split_pend_m) begin
      release_and_resume(0); run_conn(1); end_conn();
    end

    // Asynchronous reset during a connection while a split is parked.
    start_txn(1, 1, 0, ok); run_conn(1); do_split();
    start_txn(0, 0, 0, ok); run_conn(2);
    randomize_lines();
    #2;
    conn_on = 1'b0; split_pend_m = 1'b0;
    rstn = 1'b0;
    #1;
    check_all_zero("reset_mid_connect");
    m_bgrant = '0; s_split = '0;
    clear_lines();
    tick(); tick();
    rstn = 1'b1;
    tick();
    start_txn(1, 1, 0, ok); run_conn(2); end_conn();

    repeat (3) tick();
    check("ack_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
# bus_decoder

Address decoder and routing controller for the serial system bus. It sits between the master ports and the slave ports, alongside the arbiter. It snoops the device-select bits sent by the granted master and acknowledges the transaction. It then routes the serial handshake and data lines between that master and the selected slave, and tracks split transactions so the arbiter can park and later resume a split master.

## Interface
- NUM_MASTERS, 2, number of master ports (index 0 = master 1)
- NUM_SLAVES, 3, number of slave ports (index 0 = slave 1)
- DEV_W, 2, device-select bits sent MSB-first ahead of the in-slave address
- clk  in  1  bus clock
- rstn  in  1  reset, asynchronous, active-low
- m_bgrant  in  NUM_MASTERS  one-hot grant from arbiter; all-zero = bus idle
- m_wr_bus  in  NUM_MASTERS  serial write/address line per master
- m_master_valid  in  NUM_MASTERS  master valid per master
- m_master_ready  in  NUM_MASTERS  master ready per master
- m_mode  in  NUM_MASTERS  1 = write, 0 = read, per master
- m_rd_bus  out  NUM_MASTERS  serial read data to master
- m_slave_valid  out  NUM_MASTERS  routed slave valid
- m_slave_ready  out  NUM_MASTERS  routed slave ready; the decoder drives it during device select
- m_ack  out  NUM_MASTERS  one-cycle device-acknowledge pulse
- m_split  out  NUM_MASTERS  high while that master's transaction is split
- s_wr_bus, s_master_valid, s_master_ready, s_mode  out  NUM_SLAVES  routed master lines to each slave
- s_rd_bus, s_slave_valid, s_slave_ready, s_split  in  NUM_SLAVES  slave lines

## Operation
- Active master g = index of the set bit in m_bgrant. More than one bit set is illegal; the lowest index wins.
- States: IDLE, DECODE, ACK, CONNECT.
- IDLE: no routing. When m_bgrant ≠ 0, go to DECODE with bit counter 0 and the shift register cleared.
- DECODE: m_slave_ready[g]=1. Each cycle with m_master_valid[g]=1 shifts m_wr_bus[g] into dev_reg (MSB first) and increments the counter. After DEV_W bits, go to ACK.
- ACK (1 cycle):
  - If dev_reg < NUM_SLAVES and dev_reg is not the parked split slave: m_ack[g]=1, latch sel=dev_reg, go to CONNECT.
  - Otherwise: m_ack stays 0 and the state returns to IDLE (nack). The master port times out.
- CONNECT: pure combinational routing, zero latency.
  - s_*[sel] ← m_*[g]
  - m_rd_bus[g], m_slave_valid[g], m_slave_ready[g] ← s_*[sel]
  - All unselected outputs are 0.
- Leaving CONNECT: when m_bgrant[g] falls, go to IDLE.
- Split: if s_split[sel]=1 in CONNECT:
  - set split_pend, split_m=g, split_s=sel; m_split[split_m]=1;
  - drop routing next cycle; go to IDLE.
- Split release: when s_split[split_s] falls while split_pend=1, set resume_rdy.
- Resume: in IDLE with resume_rdy=1 and m_bgrant[split_m]=1:
  - skip DECODE, go to ACK with sel forced to split_s, pulse m_ack[split_m];
  - clear split_pend, resume_rdy and m_split.
- Only one split may be pending. A second s_split while pending is ignored; that transaction completes normally.
- Grant withdrawn (m_bgrant[g]=0) in DECODE or ACK: abort to IDLE with no ack.

## Timing
- Reset: every output 0; state IDLE; dev_reg, counter, sel, split_pend, resume_rdy cleared.
- Reset mid-transaction: all routing drops immediately (asynchronous).
- Decode latency: ack is asserted in the cycle after the DEV_W-th valid bit (DEV_W+1 cycles minimum from the first valid bit).
- Gaps with m_master_valid=0 in DECODE stall the counter and do not reset it.
- Split flag: m_split rises one cycle after s_split is sampled high and stays high until the resume ack cycle.
- Resume path: ack one cycle after the re-grant is seen in IDLE.
- Simultaneous split release and new grant to a different master: the new master decodes normally. It is nacked only if it targets split_s while split_pend is still set.

## Structure
- bus_pkg:
  - typedef enum for the decoder states;
  - constants NUM_MASTERS, NUM_SLAVES, DEV_W;
  - function onehot_to_idx.
- One sub-module is natural: bus_route_mux, the combinational CONNECT crossbar, parameterised on master and slave counts.

## Test plan
- Master 0 granted, sends bits 0,1 → ack pulse on m_ack[0] at cycle 3; s_master_valid[1] follows m_master_valid[0]; other slaves all 0.
- Master 1 sends device 3 (≥ NUM_SLAVES) → no ack; IDLE after ACK; no s_* activity.
- Master 0 connected to slave 2 (index 1); s_split[1]=1 → m_split[0]=1 next cycle and routing off. Master 1 targeting slave 2 → nack; targeting slave 3 → ack.
- s_split[1] falls, arbiter re-grants master 0 → m_ack[0] one cycle later without device bits; routing to slave 2 restored; m_split[0]=0.
- Valid gap: bit 1, two idle cycles, bit 0 → ack for device 2 at the correct cycle.
- rstn low during CONNECT → all outputs 0 in the same cycle; after release, state IDLE and split_pend=0.
